// File: rtl/mux_rr_canais_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_canais_if
// Purpose  : Bundle of the producer side (P_N valid/ready channels plus mode
//            and fixed select) and the consumer side (registered output with
//            valid/ready) of mux_rr_canais.
// Ports    : modo      - 0 fixed select by sel, 1 round-robin
//            sel       - channel index used in fixed mode
//            ent_dados - flattened channel data, channel i at [i*P_W +: P_W]
//            ent_valid - per-channel request
//            ent_ready - per-channel accept (at most one bit high)
//            out_dados - registered selected word
//            out_canal - channel index that produced out_dados
//            out_valid - output register holds a word
//            out_ready - consumer takes out_dados this cycle
// Modports : slave  - the multiplexer itself
//            master - producers/consumer driving it
// Revision : 1.0 - initial release
// ============================================================================
interface mux_rr_canais_if #(
  parameter int P_W = 4,
  parameter int P_N = 4
);
  localparam int P_SELW = $clog2(P_N);

  logic                  modo;
  logic [P_SELW-1:0]     sel;
  logic [P_N*P_W-1:0]    ent_dados;
  logic [P_N-1:0]        ent_valid;
  logic [P_N-1:0]        ent_ready;
  logic [P_W-1:0]        out_dados;
  logic [P_SELW-1:0]     out_canal;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  modo, sel, ent_dados, ent_valid, out_ready,
    output ent_ready, out_dados, out_canal, out_valid
  );

  modport master (
    output modo, sel, ent_dados, ent_valid, out_ready,
    input  ent_ready, out_dados, out_canal, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_rr_canais.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_canais
// Purpose  : Registered P_N-channel, P_W-bit multiplexer with valid/ready on
//            every input and on the output. Either a fixed channel (sel) or a
//            round-robin choice among requesting channels is loaded into one
//            output register stage.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - mux_rr_canais_if.slave (channels, mode, output stage)
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_canais #(
  parameter int P_W = 4,
  parameter int P_N = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mux_rr_canais_if.slave     bus
);
  localparam int P_SELW = $clog2(P_N);

  // Output stage and round-robin pointer (last granted channel)
  logic [P_W-1:0]    r_out_dados;
  logic [P_SELW-1:0] r_out_canal;
  logic              r_out_valid;
  logic [P_SELW-1:0] r_ptr;

  logic              w_carga;
  logic [P_N-1:0]    w_gnt_fixo;
  logic [P_N-1:0]    w_gnt_rr;
  logic [P_SELW-1:0] w_idx_rr;
  logic [P_N-1:0]    w_gnt;
  logic [P_SELW-1:0] w_idx;
  logic              w_tem_gnt;
  logic              w_xfer;
  logic [P_W-1:0]    w_dado;

  // The register can take a new word when empty or when being drained now.
  assign w_carga = !r_out_valid || bus.out_ready;

  // Fixed select: comparing sel against each legal index means an
  // out-of-range sel simply matches nothing, so no X and no grant.
  generate
    for (genvar i = 0; i < P_N; i++) begin : g_fixo
      assign w_gnt_fixo[i] = (bus.sel == P_SELW'(i)) && bus.ent_valid[i];
    end
  endgenerate

  // Round-robin: scan ptr+1, ptr+2, ... modulo P_N; ptr itself comes last.
  always_comb begin : p_rr
    int     c;
    logic   achou;
    w_gnt_rr = '0;
    w_idx_rr = r_ptr;
    achou    = 1'b0;
    c        = 0;
    for (int k = 1; k <= P_N; k++) begin
      c = (int'(r_ptr) + k) % P_N;
      if (!achou && bus.ent_valid[c]) begin
        achou       = 1'b1;
        w_gnt_rr[c] = 1'b1;
        w_idx_rr    = P_SELW'(c);
      end
    end
  end

  assign w_gnt     = bus.modo ? w_gnt_rr : w_gnt_fixo;
  assign w_idx     = bus.modo ? w_idx_rr : bus.sel;
  assign w_tem_gnt = |w_gnt;
  assign w_xfer    = w_carga && w_tem_gnt;

  // One-hot AND-OR data select; yields zero when nothing is granted.
  always_comb begin : p_dado
    w_dado = '0;
    for (int i = 0; i < P_N; i++) begin
      w_dado = w_dado | (bus.ent_dados[i*P_W +: P_W] & {P_W{w_gnt[i]}});
    end
  end

  // Held low during reset so nothing is accepted while state is cleared.
  assign bus.ent_ready = w_gnt & {P_N{w_carga && rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_dados <= '0;
      r_out_canal <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= P_SELW'(P_N - 1);
    end else if (w_xfer) begin
      r_out_dados <= w_dado;
      r_out_canal <= w_idx;
      r_out_valid <= 1'b1;
      r_ptr       <= w_idx;
    end else if (w_carga) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_dados = r_out_dados;
  assign bus.out_canal = r_out_canal;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire
